// File: rtl/iob_clint.sv
// Core-local interruptor: MSIP/MTIMECMP per hart plus a prescaled 64-bit MTIME, on a native slave bus.
// Registers are 32 bits wide; DATA_W must be at least 32 and ADDR_W at least 16.
module iob_clint #(
    parameter int N_CORES  = 1,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int PRESCALE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    output logic [DATA_W-1:0]     rdata,
    output logic                  ready,
    output logic [N_CORES-1:0]    mtip,
    output logic [N_CORES-1:0]    msip
);

    localparam int               PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    logic                 r_ready;
    logic [31:0]          r_rdata;
    logic [63:0]          r_mtime;
    logic [PRE_W-1:0]     r_pre;
    logic [N_CORES-1:0]   r_msip;
    logic [N_CORES-1:0]   r_mtip;
    logic [63:0]          r_mtimecmp [N_CORES];

    logic                 w_accept;
    logic                 w_we;
    logic                 w_upper_ok;
    logic [13:0]          w_word;
    logic [31:0]          w_wd;
    logic [3:0]           w_ws;
    logic                 w_sel_msip;
    logic                 w_sel_cmp;
    logic                 w_sel_mtlo;
    logic                 w_sel_mthi;
    logic [3:0]           w_msip_idx;
    logic [3:0]           w_cmp_idx;
    logic                 w_cmp_hi;
    logic                 w_inc;
    logic                 w_mt_wr;
    logic [63:0]          w_mtime_inc;
    logic [63:0]          w_mtime_nxt;
    logic [31:0]          w_rval;
    logic                 w_unused;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                            input logic [3:0] strb);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    assign w_accept   = valid & ~r_ready;
    assign w_we       = w_accept & (|wstrb);
    assign w_wd       = wdata[31:0];
    assign w_ws       = wstrb[3:0];
    assign w_unused   = ^address[1:0];

    // Word-granular decode; any address bit above the 64 KiB window makes the access unmapped.
    assign w_upper_ok = ((address >> 16) == '0);
    assign w_word     = address[15:2];
    assign w_sel_msip = w_upper_ok && (w_word[13:4] == 10'h000);
    assign w_sel_cmp  = w_upper_ok && (w_word[13:5] == 9'h080);
    assign w_sel_mtlo = w_upper_ok && (w_word == 14'h2FFE);
    assign w_sel_mthi = w_upper_ok && (w_word == 14'h2FFF);
    assign w_msip_idx = w_word[3:0];
    assign w_cmp_idx  = w_word[4:1];
    assign w_cmp_hi   = w_word[0];

    assign w_inc       = (r_pre == PRE_MAX);
    assign w_mt_wr     = w_we && (w_sel_mtlo || w_sel_mthi);
    assign w_mtime_inc = r_mtime + 64'(w_inc);

    // Written lanes override the incremented value; unwritten lanes and the other half keep it.
    always_comb begin
        w_mtime_nxt = w_mtime_inc;
        if (w_we && w_sel_mtlo) w_mtime_nxt[31:0]  = f_merge(w_mtime_inc[31:0], w_wd, w_ws);
        if (w_we && w_sel_mthi) w_mtime_nxt[63:32] = f_merge(w_mtime_inc[63:32], w_wd, w_ws);
    end

    always_comb begin
        w_rval = '0;
        if (w_sel_mtlo) w_rval = r_mtime[31:0];
        if (w_sel_mthi) w_rval = r_mtime[63:32];
        for (int h = 0; h < N_CORES; h++) begin
            if (w_sel_msip && (w_msip_idx == 4'(h))) w_rval = {31'b0, r_msip[h]};
            if (w_sel_cmp && (w_cmp_idx == 4'(h)))
                w_rval = w_cmp_hi ? r_mtimecmp[h][63:32] : r_mtimecmp[h][31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_mtime <= '0;
            r_pre   <= '0;
            r_msip  <= '0;
            r_mtip  <= '0;
            for (int h = 0; h < N_CORES; h++) r_mtimecmp[h] <= '1;
        end else begin
            r_ready <= w_accept;
            r_rdata <= (w_accept && !(|wstrb)) ? w_rval : 32'h0;
            r_mtime <= w_mtime_nxt;
            r_pre   <= (w_mt_wr || w_inc) ? '0 : r_pre + PRE_W'(1);
            for (int h = 0; h < N_CORES; h++) begin
                if (w_we && w_sel_msip && (w_msip_idx == 4'(h)) && w_ws[0]) r_msip[h] <= w_wd[0];
                if (w_we && w_sel_cmp && (w_cmp_idx == 4'(h))) begin
                    if (w_cmp_hi)
                        r_mtimecmp[h][63:32] <= f_merge(r_mtimecmp[h][63:32], w_wd, w_ws);
                    else
                        r_mtimecmp[h][31:0]  <= f_merge(r_mtimecmp[h][31:0], w_wd, w_ws);
                end
                // Compare current register values, giving one cycle of latency after any update.
                r_mtip[h] <= (r_mtime >= r_mtimecmp[h]);
            end
        end
    end

    assign ready = r_ready;
    assign rdata = DATA_W'(r_rdata);
    assign mtip  = r_mtip;
    assign msip  = r_msip;

endmodule

// File: tb/tb_iob_clint.sv
// Directed bench for iob_clint: a 2-hart PRESCALE=1 instance and a 1-hart PRESCALE=4 instance.
module tb_iob_clint;

    logic        clk = 1'b0;
    logic        rst;

    logic        valid;
    logic [15:0] address;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;
    logic [1:0]  mtip;
    logic [1:0]  msip;

    logic        valid4;
    logic [15:0] address4;
    logic [31:0] wdata4;
    logic [3:0]  wstrb4;
    logic [31:0] rdata4;
    logic        ready4;
    logic [0:0]  mtip4;
    logic [0:0]  msip4;

    int n_chk = 0;
    int n_err = 0;
    int n_pulse;
    logic [31:0] d;
    logic [31:0] exp4 [4];

    always #5 clk = ~clk;

    iob_clint #(.N_CORES(2), .ADDR_W(16), .DATA_W(32), .PRESCALE(1)) dut (
        .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata), .wstrb(wstrb),
        .rdata(rdata), .ready(ready), .mtip(mtip), .msip(msip)
    );

    iob_clint #(.N_CORES(1), .ADDR_W(16), .DATA_W(32), .PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst), .valid(valid4), .address(address4), .wdata(wdata4), .wstrb(wstrb4),
        .rdata(rdata4), .ready(ready4), .mtip(mtip4), .msip(msip4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One transaction: drive at negedge, accept at next posedge, sample ready/rdata at following negedge.
    task automatic bus(input bit s4, input logic [15:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, output logic [31:0] rd);
        @(negedge clk);
        if (s4) begin
            valid4 = 1'b1; address4 = a; wdata4 = wd; wstrb4 = ws;
        end else begin
            valid = 1'b1; address = a; wdata = wd; wstrb = ws;
        end
        @(posedge clk);
        #1;
        valid  = 1'b0;
        valid4 = 1'b0;
        @(negedge clk);
        chk("ready_pulse", s4 ? ready4 : ready, 1);
        rd = s4 ? rdata4 : rdata;
        if (ws != 4'h0) chk("write_rdata_zero", rd, 0);
    endtask

    task automatic wr(input bit s4, input logic [15:0] a, input logic [31:0] wd, input logic [3:0] ws);
        logic [31:0] dummy;
        bus(s4, a, wd, ws, dummy);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        valid = 1'b0; address = '0; wdata = '0; wstrb = '0;
        valid4 = 1'b0; address4 = '0; wdata4 = '0; wstrb4 = '0;
        exp4[0] = 32'd0; exp4[1] = 32'd0; exp4[2] = 32'd1; exp4[3] = 32'd1;

        // Reset state and MTIME counting at PRESCALE=1
        do_reset();
        @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mtip", mtip, 0);
        chk("rst_msip", msip, 0);
        chk("rst_ready4", ready4, 0);
        chk("rst_mtip4", mtip4, 0);
        chk("rst_msip4", msip4, 0);
        repeat (10) @(posedge clk);
        bus(0, 16'hBFF8, 0, 4'h0, d); chk("mtime_lo_at10", d, 32'd10);
        bus(0, 16'h4000, 0, 4'h0, d); chk("cmp0_lo_rst", d, 32'hFFFF_FFFF);
        bus(0, 16'h4004, 0, 4'h0, d); chk("cmp0_hi_rst", d, 32'hFFFF_FFFF);
        bus(0, 16'h400C, 0, 4'h0, d); chk("cmp1_hi_rst", d, 32'hFFFF_FFFF);
        bus(0, 16'h1000, 0, 4'h0, d); chk("unmapped_rd", d, 0);
        bus(0, 16'h4010, 0, 4'h0, d); chk("cmp2_absent", d, 0);

        // MTIMECMP -> mtip timing
        do_reset();
        wr(0, 16'h4004, 32'h0, 4'hF);
        wr(0, 16'h4000, 32'h20, 4'hF);
        repeat (29) @(negedge clk);
        chk("mtip_before", mtip, 2'b00);
        @(negedge clk);
        chk("mtip_rise", mtip, 2'b01);
        wr(0, 16'h4004, 32'h1, 4'hF);
        chk("mtip_hold", mtip, 2'b01);
        @(negedge clk);
        chk("mtip_fall", mtip, 2'b00);
        wr(0, 16'h400C, 32'h0, 4'hF);
        wr(0, 16'h4008, 32'h0, 4'hF);
        chk("mtip1_lat", mtip, 2'b00);
        @(negedge clk);
        chk("mtip1_rise", mtip, 2'b10);

        // MSIP
        do_reset();
        wr(0, 16'h0000, 32'h1, 4'h1);        chk("msip0_set", msip, 2'b01);
        bus(0, 16'h0000, 0, 4'h0, d);        chk("msip0_rd", d, 1);
        wr(0, 16'h0000, 32'hFFFF_FFFF, 4'hF);
        bus(0, 16'h0000, 0, 4'h0, d);        chk("msip0_rd_bit0", d, 1);
        wr(0, 16'h0004, 32'h1, 4'h1);        chk("msip1_set", msip, 2'b11);
        wr(0, 16'h0000, 32'h0, 4'h1);        chk("msip0_clr", msip, 2'b10);
        wr(0, 16'h0008, 32'h1, 4'h1);        chk("msip_oob_wr", msip, 2'b10);
        bus(0, 16'h0008, 0, 4'h0, d);        chk("msip_oob_rd", d, 0);
        wr(0, 16'h0000, 32'h101, 4'h2);      chk("msip_lane0_off", msip, 2'b10);

        // MTIME writes, carry, wrap, and lane merge with increment
        do_reset();
        wr(0, 16'hBFFC, 32'h0, 4'hF);
        wr(0, 16'hBFF8, 32'hFFFF_FFFF, 4'hF);
        bus(0, 16'hBFFC, 0, 4'h0, d);        chk("carry_hi", d, 1);
        bus(0, 16'hBFF8, 0, 4'h0, d);        chk("carry_lo", d, 2);
        wr(0, 16'hBFFC, 32'hFFFF_FFFF, 4'hF);
        wr(0, 16'hBFF8, 32'hFFFF_FFFF, 4'hF);
        bus(0, 16'hBFFC, 0, 4'h0, d);        chk("wrap_hi", d, 0);
        bus(0, 16'hBFF8, 0, 4'h0, d);        chk("wrap_lo", d, 2);
        wr(0, 16'hBFF8, 32'h0000_7700, 4'h2);
        bus(0, 16'hBFF8, 0, 4'h0, d);        chk("lane_merge_lo", d, 32'h7706);
        wr(0, 16'hBFFC, 32'h0, 4'hF);
        wr(0, 16'hBFF8, 32'hFFFF_FFFE, 4'hF);
        wr(0, 16'hBFFC, 32'h0000_0500, 4'h2);
        bus(0, 16'hBFFC, 0, 4'h0, d);        chk("hi_merge_carry", d, 32'h501);
        bus(0, 16'hBFF8, 0, 4'h0, d);        chk("lo_after_hi_wr", d, 3);

        // PRESCALE=4 with valid held high
        do_reset();
        @(negedge clk);
        valid4 = 1'b1; address4 = 16'hBFF8; wdata4 = '0; wstrb4 = 4'h0;
        n_pulse = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("held_ready_%0d", i), ready4, (i % 2 == 0) ? 1 : 0);
            if (ready4) n_pulse++;
            if (i % 2 == 0) chk($sformatf("held_rdata_%0d", i), rdata4, exp4[i/2]);
        end
        valid4 = 1'b0;
        chk("held_pulses", n_pulse, 4);
        wr(1, 16'hBFF8, 32'h100, 4'hF);
        bus(1, 16'hBFF8, 0, 4'h0, d);        chk("pre_wr_a", d, 32'h100);
        bus(1, 16'hBFF8, 0, 4'h0, d);        chk("pre_wr_b", d, 32'h100);
        bus(1, 16'hBFF8, 0, 4'h0, d);        chk("pre_wr_c", d, 32'h101);

        // Byte write to MTIMECMP, then reset right after an accepted request
        do_reset();
        wr(0, 16'h4000, 32'h0000_AB00, 4'h2);
        bus(0, 16'h4000, 0, 4'h0, d);        chk("cmp_byte_lo", d, 32'hFFFF_ABFF);
        bus(0, 16'h4004, 0, 4'h0, d);        chk("cmp_byte_hi", d, 32'hFFFF_FFFF);
        wr(0, 16'h0000, 32'h1, 4'h1);
        @(negedge clk);
        valid = 1'b1; address = 16'h0004; wdata = 32'h1; wstrb = 4'h1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_pend_ready", ready, 0);
        chk("rst_pend_rdata", rdata, 0);
        chk("rst_pend_msip", msip, 2'b00);
        chk("rst_pend_mtip", mtip, 2'b00);
        @(negedge clk);
        chk("rst_pend_ready2", ready, 0);
        bus(0, 16'hBFF8, 0, 4'h0, d);        chk("rst_mtime", d, 2);
        bus(0, 16'h4000, 0, 4'h0, d);        chk("rst_cmp_lo", d, 32'hFFFF_FFFF);
        bus(0, 16'h0000, 0, 4'h0, d);        chk("rst_msip0_rd", d, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/iob_clint.md
IOB_CLINT -- requirements
Module: iob_clint

Interface
REQ-001 SHALL have parameter N_CORES, default 1, number of harts served (1..16).
REQ-002 SHALL have parameter ADDR_W, default 16, byte-address width of the slave port.
REQ-003 SHALL have parameter DATA_W, default 32, data width of the slave port.
REQ-004 SHALL have parameter PRESCALE, default 1, clk cycles per mtime increment (>=1).
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 valid  input  1  native-bus request valid.
REQ-008 address  input  ADDR_W  byte address; bits [1:0] ignored.
REQ-009 wdata  input  DATA_W  write data.
REQ-010 wstrb  input  DATA_W/8  byte strobes; all-zero means read.
REQ-011 rdata  output  DATA_W  read data, meaningful only while ready=1.
REQ-012 ready  output  1  one-cycle completion pulse for the accepted request.
REQ-013 mtip  output  N_CORES  per-hart timer interrupt; drives CPU timerInterrupt.
REQ-014 msip  output  N_CORES  per-hart software interrupt; drives CPU softwareInterrupt.

Function
REQ-015 Register map (byte offset): MSIP[h] 0x0000+4h (bit0 only, others read 0); MTIMECMP[h] lo 0x4000+8h, hi 0x4004+8h; MTIME lo 0xBFF8, hi 0xBFFC.
REQ-016 Request accepted when valid=1 and ready=0; ready SHALL be 1 exactly the following cycle, then 0; valid held high gives one completion every 2 cycles.
REQ-017 Read: rdata SHALL be the register value sampled at accept, registered, presented with ready.
REQ-018 Write: each byte lane with wstrb=1 SHALL update at the accept edge; other lanes unchanged; rdata=0 on writes.
REQ-019 Unmapped or hart index >= N_CORES: reads return 0, writes ignored, ready still pulses.
REQ-020 Prescaler: counter 0..PRESCALE-1, wraps to 0; mtime SHALL increment by 1 on the edge where counter equals PRESCALE-1; PRESCALE=1 increments every cycle.
REQ-021 mtime is 64-bit; 0xFFFF_FFFF_FFFF_FFFF + 1 SHALL wrap to 0.
REQ-022 Write to MTIME lo/hi in the same cycle as an increment: written lanes take written value, unwritten lanes of that word take the incremented value; the other 32-bit half keeps incremented value (lo-to-hi carry included).
REQ-023 Writing any MTIME half SHALL reset the prescaler counter to 0.
REQ-024 mtip[h] SHALL be registered: mtip[h] = (mtime >= MTIMECMP[h]) evaluated on the post-edge register values, one cycle latency; unsigned 64-bit compare.
REQ-025 msip[h] SHALL equal MSIP[h] bit0 directly from its register (zero added latency after write edge).
REQ-026 Write to MTIMECMP[h] SHALL affect mtip[h] one cycle after the write edge; no other hart affected.

Reset
REQ-027 On rst=1 at a clock edge: ready=0, rdata=0, mtime=0, prescaler=0, all MSIP=0, all MTIMECMP=0xFFFF_FFFF_FFFF_FFFF, mtip=0, msip=0.
REQ-028 rst during a pending request SHALL drop it; no ready pulse for it after reset; rst has priority over all writes and increments.

Verification
REQ-029 Reset, PRESCALE=1, read MTIME lo at cycle 10 after reset release -> rdata matches cycle count at accept (10), ready one cycle later; MTIMECMP[0] lo reads 0xFFFF_FFFF.
REQ-030 Write MTIMECMP[0]=0x20 (hi=0 then lo=0x20) -> mtip[0] rises exactly the cycle after mtime reaches 0x20 (registered); rewrite MTIMECMP[0] hi=1 -> mtip[0] falls one cycle after.
REQ-031 Write MSIP[0] wdata=1 wstrb=0x1 -> msip[0]=1 after the edge; write 0 -> msip[0]=0; write MSIP[N_CORES] -> no msip change, ready pulses, readback 0.
REQ-032 Write MTIME lo=0xFFFF_FFFF, hi=0 with PRESCALE=1 -> after next increment hi=1, lo=0; write hi=lo=0xFFFF_FFFF -> wraps to 0.
REQ-033 PRESCALE=4, valid held high for 8 cycles reading MTIME lo -> 4 ready pulses, alternating cycles; mtime increments once per 4 cycles.
REQ-034 Byte write wstrb=0x2 wdata=0x0000_AB00 to MTIMECMP[0] lo after reset -> lo reads 0xFFFF_ABFF; rst asserted cycle after accept -> no ready pulse, all registers at reset values.
